// File: rtl/disp7_pkg.sv
// disp7_pkg: shared types and constants for the 7-segment scan controller.
//  Exports: state_e (IDLE/BLANK/SHOW), SEG_OFF (all segments dark),
//  SEG_LUT (active-low {a,b,c,d,e,f,g} pattern per hex nibble).
package disp7_pkg;

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_e;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    localparam logic [6:0] SEG_LUT [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

endpackage

// File: rtl/scan_slot_timer.sv
// scan_slot_timer: per-digit slot counter and digit index for the scan controller.
//  i_Clk, i_Rst_n : clock, asynchronous active-low reset
//  i_Run          : 1 = advance the counter; 0 = hold counter and index at 0
//  o_Idx          : digit currently being scanned
//  o_In_Blank     : counter is inside the blanking window of the slot
//  o_Blank_End    : last blanking cycle of the slot
//  o_Slot_End     : last cycle of the slot
//  o_Frame_End    : last cycle of the slot of the last digit
module scan_slot_timer #(
    parameter int N_DIGITS  = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500,
    localparam int CW = $clog2(SCAN_DIV),
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic          i_Clk,
    input  logic          i_Rst_n,
    input  logic          i_Run,
    output logic [IW-1:0] o_Idx,
    output logic          o_In_Blank,
    output logic          o_Blank_End,
    output logic          o_Slot_End,
    output logic          o_Frame_End
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          last_idx;

    always_comb begin
        last_idx    = idx_q == IW'(N_DIGITS - 1);
        o_Slot_End  = cnt_q == CW'(SCAN_DIV - 1);
        o_Blank_End = cnt_q == CW'(BLANK_CYC - 1);
        o_In_Blank  = cnt_q < CW'(BLANK_CYC);
        o_Frame_End = o_Slot_End && last_idx;
        o_Idx       = idx_q;
        cnt_d       = (i_Run && !o_Slot_End) ? cnt_q + CW'(1) : '0;
        idx_d       = !i_Run ? '0 : !o_Slot_End ? idx_q : last_idx ? '0 : idx_q + IW'(1);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed scan controller for an N-digit common-anode 7-segment display.
//  i_Clk, i_Rst_n : clock, asynchronous active-low reset
//  i_Enable       : 1 = scanning, 0 = display dark
//  i_Data/i_Load/o_Ready : valid/ready capture of a new hex value into the pending buffer
//  i_Blank_Mask   : per-digit force-dark
//  o_Anodos       : active-low digit enables (at most one low)
//  o_Segmentos    : active-low segments {a,b,c,d,e,f,g}
//  o_Frame_Done   : one-cycle pulse on the last cycle of the last digit slot
module display_scan_ctrl
    import disp7_pkg::*;
#(
    parameter int N_DIGITS  = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500,
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_n,
    input  logic                  i_Enable,
    input  logic [4*N_DIGITS-1:0] i_Data,
    input  logic                  i_Load,
    output logic                  o_Ready,
    input  logic [N_DIGITS-1:0]   i_Blank_Mask,
    output logic [N_DIGITS-1:0]   o_Anodos,
    output logic [6:0]            o_Segmentos,
    output logic                  o_Frame_Done
);

    state_e                state_q, state_d;
    logic [4*N_DIGITS-1:0] disp_q, disp_d, pend_q, pend_d;
    logic                  pend_vld_q, pend_vld_d;
    logic                  ready_q, ready_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  fd_q, fd_d;

    logic          run, in_blank, blank_end, slot_end, frame_end;
    logic          frame_evt, capture, commit, show;
    logic [IW-1:0] idx;
    logic [3:0]    nib;

    scan_slot_timer #(
        .N_DIGITS  (N_DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_timer (
        .i_Clk       (i_Clk),
        .i_Rst_n     (i_Rst_n),
        .i_Run       (run),
        .o_Idx       (idx),
        .o_In_Blank  (in_blank),
        .o_Blank_End (blank_end),
        .o_Slot_End  (slot_end),
        .o_Frame_End (frame_end)
    );

    always_comb begin
        run        = i_Enable && state_q != IDLE;
        state_d    = !i_Enable ? IDLE :
                     state_q == IDLE ? BLANK :
                     (state_q == BLANK && blank_end) ? SHOW :
                     (state_q == SHOW && slot_end) ? BLANK : state_q;
        frame_evt  = i_Enable && state_q == SHOW && frame_end;
        capture    = i_Load && ready_q;
        // Commit only between frames so one frame never mixes old and new digits;
        // with the scan stopped there is no frame to protect.
        commit     = pend_vld_q && (frame_evt || state_q == IDLE);
        pend_d     = capture ? i_Data : pend_q;
        pend_vld_d = capture ? 1'b1 : commit ? 1'b0 : pend_vld_q;
        disp_d     = commit ? pend_q : disp_q;
        // Stays low through the commit cycle and rises the cycle after.
        ready_d    = !(capture || pend_vld_q);
        nib        = disp_q[{idx, 2'b00} +: 4];
        show       = i_Enable && state_q == SHOW && !in_blank && !i_Blank_Mask[idx];
        an_d       = show ? ~(N_DIGITS'(1) << idx) : '1;
        seg_d      = show ? SEG_LUT[nib] : SEG_OFF;
        fd_d       = frame_evt;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q    <= IDLE;
            disp_q     <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            ready_q    <= 1'b1;
            an_q       <= '1;
            seg_q      <= SEG_OFF;
            fd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            disp_q     <= disp_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            ready_q    <= ready_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            fd_q       <= fd_d;
        end
    end

    assign o_Ready      = ready_q;
    assign o_Anodos     = an_q;
    assign o_Segmentos  = seg_q;
    assign o_Frame_Done = fd_q;

endmodule
